// File: rtl/conc_sched.sv
// conc_sched: round-robin scheduler for the conc datapath (a=i+K, b=3a, c=a+b, d=i-1, e=j/4).
// All arithmetic runs on one shared adder over four cycles; results come back on a valid/ready channel.
module conc_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADD_K = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_i,
    input  logic [WIDTH-1:0] req0_j,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_i,
    input  logic [WIDTH-1:0] req1_j,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_a,
    output logic [WIDTH-1:0] rsp_b,
    output logic [WIDTH-1:0] rsp_c,
    output logic [WIDTH-1:0] rsp_d,
    output logic [WIDTH-1:0] rsp_e,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_A  = 3'd1,
        S_B  = 3'd2,
        S_C  = 3'd3,
        S_D  = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_a_q, rsp_a_d;
    logic [WIDTH-1:0] rsp_b_q, rsp_b_d;
    logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
    logic [WIDTH-1:0] rsp_d_q, rsp_d_d;
    logic [WIDTH-1:0] rsp_e_q, rsp_e_d;
    logic             busy_q, busy_d;

    logic             gnt0_s, gnt1_s;
    logic [WIDTH-1:0] add_x_s, add_y_s, add_sum_s;

    // Round-robin grant, only offered while idle; a tie goes to the requester not served last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0_s = last_grant_q;
                gnt1_s = ~last_grant_q;
            end else begin
                gnt0_s = req0_valid;
                gnt1_s = req1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Operand mux for the single shared adder; 3a is formed as a + (a << 1).
    always_comb begin
        add_x_s = {WIDTH{1'b0}};
        add_y_s = {WIDTH{1'b0}};
        case (state_q)
            S_A: begin
                add_x_s = i_q;
                add_y_s = WIDTH'(ADD_K);
            end
            S_B: begin
                add_x_s = rsp_a_q;
                add_y_s = rsp_a_q << 1'b1;
            end
            S_C: begin
                add_x_s = rsp_a_q;
                add_y_s = rsp_b_q;
            end
            S_D: begin
                add_x_s = i_q;
                add_y_s = {WIDTH{1'b1}};
            end
            default: begin
                add_x_s = {WIDTH{1'b0}};
                add_y_s = {WIDTH{1'b0}};
            end
        endcase
    end

    assign add_sum_s = add_x_s + add_y_s;

    // Next-state and datapath update; each arithmetic state lasts one cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_d          = i_q;
        j_d          = j_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_a_d      = rsp_a_q;
        rsp_b_d      = rsp_b_q;
        rsp_c_d      = rsp_c_q;
        rsp_d_d      = rsp_d_q;
        rsp_e_d      = rsp_e_q;
        case (state_q)
            IDLE: begin
                if (gnt0_s || gnt1_s) begin
                    i_d          = gnt1_s ? req1_i : req0_i;
                    j_d          = gnt1_s ? req1_j : req0_j;
                    id_d         = gnt1_s;
                    last_grant_d = gnt1_s;
                    state_d      = S_A;
                end else begin
                    state_d = IDLE;
                end
            end
            S_A: begin
                rsp_a_d = add_sum_s;
                rsp_e_d = j_q >> 2'd2;
                state_d = S_B;
            end
            S_B: begin
                rsp_b_d = add_sum_s;
                state_d = S_C;
            end
            S_C: begin
                rsp_c_d = add_sum_s;
                state_d = S_D;
            end
            S_D: begin
                rsp_d_d  = add_sum_s;
                rsp_id_d = id_q;
                state_d  = OUT;
            end
            OUT: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    // State and result registers; reset discards any in-flight job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            i_q          <= {WIDTH{1'b0}};
            j_q          <= {WIDTH{1'b0}};
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_a_q      <= {WIDTH{1'b0}};
            rsp_b_q      <= {WIDTH{1'b0}};
            rsp_c_q      <= {WIDTH{1'b0}};
            rsp_d_q      <= {WIDTH{1'b0}};
            rsp_e_q      <= {WIDTH{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_q          <= i_d;
            j_q          <= j_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_a_q      <= rsp_a_d;
            rsp_b_q      <= rsp_b_d;
            rsp_c_q      <= rsp_c_d;
            rsp_d_q      <= rsp_d_d;
            rsp_e_q      <= rsp_e_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_d     = rsp_d_q;
    assign rsp_e     = rsp_e_q;
    assign busy      = busy_q;

endmodule
